alu_error_monitor: RTL

Registered error-reporting stage placed directly downstream of the ALU error-flag logic. Samples the combinational error flag and the operation selector whenever an operation is committed, and latches the error cause. Keeps a saturating error count and drives LEDR9 with a blinking pattern while an error is held. Turns the transient, selector-dependent flag into a stable, human-readable indication on the board.

---
 rtl/alu_error_monitor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_error_monitor.sv
// alu_error_monitor: registered error-reporting stage behind the ALU flag logic.
// Captures the error cause on each committed operation, keeps a saturating
// error count and blinks ledr9 while an error is held.
// Optional feature macro: ERR_STICKY_EN. When it is defined, an error is held
// until clear or rst. When it is undefined, a clean commit auto-clears the error.
module alu_error_monitor #(
    parameter int unsigned BLINK_HALF = 25_000_000,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec,
    input  logic             err_in,
    input  logic [2:0]       seletor,
    input  logic             clear,
    output logic             ledr9,
    output logic             err_active,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cnt
);

    // A one-cycle half-period still needs a 1-bit counter.
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BlinkLast = BW'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic {
        StOk,
        StErr
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]    blink_q, blink_d;
    logic             phase_q, phase_d;

    // Cause decode: unknown selectors with an error flag map to the unused-opcode code.
    function automatic logic [1:0] decode_cause(input logic [2:0] sel);
        logic [1:0] cause;
        case (sel)
            3'b001:  cause = 2'b01;
            3'b110:  cause = 2'b10;
            3'b111:  cause = 2'b11;
            default: cause = 2'b11;
        endcase
        return cause;
    endfunction

    // Next-state logic: clear has priority over exec in both states.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        phase_d = phase_q;

        if (clear) begin
            if (state_q == StErr) begin
                state_d = StOk;
                code_d  = 2'b00;
                blink_d = '0;
                phase_d = 1'b0;
            end
        end else if (exec && err_in) begin
            // Capture or re-capture: the blink restarts with the LED on.
            state_d = StErr;
            code_d  = decode_cause(seletor);
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            blink_d = '0;
            phase_d = 1'b1;
        end else if (state_q == StErr) begin
`ifdef ERR_STICKY_EN
            // Clean commits are ignored; the blink keeps running.
            if (blink_q == BlinkLast) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
`else
            if (exec) begin
                // A clean commit auto-clears the held error.
                state_d = StOk;
                code_d  = 2'b00;
                blink_d = '0;
                phase_d = 1'b0;
            end else if (blink_q == BlinkLast) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
`endif
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StOk;
            code_q  <= 2'b00;
            cnt_q   <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
        end
    end

    // Phase is forced low whenever the FSM is in StOk, so it drives the LED directly.
    assign ledr9      = phase_q;
    assign err_active = (state_q == StErr);
    assign err_code   = code_q;
    assign err_cnt    = cnt_q;

endmodule
